// File: rtl/pll_rst_seq_pkg.sv
// Shared types and default constants for the PLL reset sequencer.
package pll_rst_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    REL_SYS,
    REL_CORE,
    RUN
  } state_t;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_HOLD      = 1000;
  localparam int DEF_STAGE_GAP      = 16;
  localparam int DEF_RELOCK_TIMEOUT = 100000;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/pll_rst_seq_sync.sv
// Multi-flop synchronizer for the asynchronous PLL lock indication.
module pll_rst_seq_sync
  import pll_rst_seq_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset and staged domain-reset release sequencer.
// Optional lock-loss counter output enabled by PLL_RST_SEQ_LOSS_CNT_EN.
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_HOLD      = DEF_LOCK_HOLD,
  parameter int STAGE_GAP      = DEF_STAGE_GAP,
  parameter int RELOCK_TIMEOUT = DEF_RELOCK_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_locked,
  output logic pll_rst,
  output logic sys_rst_n,
  output logic core_rst_n,
  output logic periph_rst_n,
  output logic ready
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0] loss_cnt
`endif
);

  localparam int CNT_MAX = max4(PLL_RST_CYCLES, LOCK_HOLD, STAGE_GAP, RELOCK_TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             locked_s;

  // Counter holds the remaining evaluations in the current state; 1 means last.
  // STABLE loads one less because the WAIT_LOCK cycle that saw lock already counts.
  function automatic logic [CNT_W-1:0] reload(input state_t s);
    case (s)
      PLL_RST:            reload = CNT_W'(PLL_RST_CYCLES);
      WAIT_LOCK:          reload = CNT_W'(RELOCK_TIMEOUT);
      STABLE:             reload = CNT_W'(LOCK_HOLD - 1);
      REL_SYS, REL_CORE:  reload = CNT_W'(STAGE_GAP);
      default:            reload = '0;
    endcase
  endfunction

  pll_rst_seq_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt != '0) ? cnt - CNT_W'(1) : '0;
    case (state)
      PLL_RST: begin
        // A cleared counter only occurs straight out of reset: arm the window here.
        if (cnt == '0 && PLL_RST_CYCLES > 1) cnt_nxt   = CNT_W'(PLL_RST_CYCLES - 1);
        else if (cnt <= CNT_W'(1))           state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s)                state_nxt = STABLE;
        else if (cnt <= CNT_W'(1))   state_nxt = PLL_RST;
      end
      STABLE: begin
        if (!locked_s)               state_nxt = WAIT_LOCK;
        else if (cnt <= CNT_W'(1))   state_nxt = REL_SYS;
      end
      REL_SYS: begin
        if (!locked_s)               state_nxt = PLL_RST;
        else if (cnt <= CNT_W'(1))   state_nxt = REL_CORE;
      end
      REL_CORE: begin
        if (!locked_s)               state_nxt = PLL_RST;
        else if (cnt <= CNT_W'(1))   state_nxt = RUN;
      end
      RUN: begin
        if (!locked_s)               state_nxt = PLL_RST;
      end
      default: state_nxt = PLL_RST;
    endcase
    if (state_nxt != state) cnt_nxt = reload(state_nxt);
  end

  // Outputs are decoded from the next state so they change on the same edge as state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= PLL_RST;
      cnt          <= '0;
      pll_rst      <= 1'b1;
      sys_rst_n    <= 1'b0;
      core_rst_n   <= 1'b0;
      periph_rst_n <= 1'b0;
      ready        <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      pll_rst      <= (state_nxt == PLL_RST);
      sys_rst_n    <= (state_nxt == REL_SYS) || (state_nxt == REL_CORE) || (state_nxt == RUN);
      core_rst_n   <= (state_nxt == REL_CORE) || (state_nxt == RUN);
      periph_rst_n <= (state_nxt == RUN);
      ready        <= (state_nxt == RUN);
    end
  end

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Only lock loss after release or a WAIT_LOCK timeout can lead back into PLL_RST.
  logic loss_evt;
  assign loss_evt = (state_nxt == PLL_RST) && (state != PLL_RST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        loss_cnt <= 8'd0;
    else if (loss_evt) loss_cnt <= sat_inc8(loss_cnt);
  end
`endif

endmodule
